// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// Build option BCD_SATURATE_EN: an out-of-range operand reports all-nines instead of value mod 10^N_DIG.
//
// state | meaning
// IDLE  | waiting for start_i; operand captured on the accepting edge
// SHIFT | one add-3/shift step per cycle, BIN_W cycles total
// DONE  | result registers just loaded; done_o high for this one cycle
module bin_to_bcd_seq #(
  parameter int BIN_W = 20,
  parameter int N_DIG = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [BIN_W-1:0]   bin_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               ovf_o,
  output logic [4*N_DIG-1:0] bcd_o
);

  function automatic int dec_digits(input int w);
    longint unsigned v;
    int n;
    v = (64'd1 << w) - 64'd1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 64'd0) begin
        v = v / 64'd10;
        n++;
      end
    end
    return n;
  endfunction

  // Scratch must hold the full decimal value of any operand, and always has at
  // least one digit above the output so overflow is a simple nonzero test.
  localparam int NEED_DIG = dec_digits(BIN_W);
  localparam int SCR_DIG  = (NEED_DIG > N_DIG + 1) ? NEED_DIG : N_DIG + 1;
  localparam int SCR_W    = 4 * SCR_DIG;
  localparam int CNT_W    = $clog2(BIN_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [BIN_W-1:0]       shreg_q;
  logic [SCR_W-1:0]       scr_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [SCR_W-1:0]       adj;
  logic [SCR_W+BIN_W-1:0] cat_sh;
  logic [SCR_W-1:0]       scr_d;
  logic [BIN_W-1:0]       sh_d;
  logic                   last;
  logic                   ovf_nx;
  logic [4*N_DIG-1:0]     bcd_nx;

  assign last = (cnt_q == CNT_W'(BIN_W - 1));

  always_comb begin
    adj = scr_q;
    for (int i = 0; i < SCR_DIG; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
    cat_sh = {adj, shreg_q} << 1;
    scr_d  = cat_sh[SCR_W+BIN_W-1:BIN_W];
    sh_d   = cat_sh[BIN_W-1:0];
  end

  // Result is taken from the scratch value produced by the final shift, so the
  // output registers load on the same edge that enters DONE.
  always_comb begin
    ovf_nx = |scr_d[SCR_W-1:4*N_DIG];
`ifdef BCD_SATURATE_EN
    bcd_nx = ovf_nx ? {N_DIG{4'h9}} : scr_d[4*N_DIG-1:0];
`else
    bcd_nx = scr_d[4*N_DIG-1:0];
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = SHIFT;
      end
      SHIFT: begin
        busy_o = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg_q <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_o   <= '0;
      ovf_o   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            shreg_q <= bin_i;
            scr_q   <= '0;
            cnt_q   <= '0;
          end
        end
        SHIFT: begin
          shreg_q <= sh_d;
          scr_q   <= scr_d;
          cnt_q   <= cnt_q + 1'b1;
          if (last) begin
            bcd_o <= bcd_nx;
            ovf_o <= ovf_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: latency, handshake, overflow, reset abort.
// Expected results follow BCD_SATURATE_EN the same way the design does.
module tb_bin_to_bcd_seq;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [19:0] bin_i;
  logic        busy_o;
  logic        done_o;
  logic        ovf_o;
  logic [23:0] bcd_o;

  int n_chk    = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int cyc_ctr  = 0;

  bin_to_bcd_seq #(.BIN_W(20), .N_DIG(6)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .bin_i   (bin_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .ovf_o   (ovf_o),
    .bcd_o   (bcd_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    cyc_ctr <= cyc_ctr + 1;
    if (done_o) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [23:0] ref_bcd(input int unsigned v);
    logic [23:0] r;
    int unsigned t;
    r = '0;
    t = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
`ifdef BCD_SATURATE_EN
    if (v > 999999) r = 24'h999999;
`endif
    return r;
  endfunction

  task automatic run_conv(input logic [19:0] v, input logic [23:0] exp_bcd,
                          input logic exp_ovf, input string tag);
    int cyc, busy_cnt, d0;
    @(negedge clk_i);
    start_i = 1'b1;
    bin_i   = v;
    d0      = done_cnt;
    @(negedge clk_i);
    start_i  = 1'b0;
    cyc      = 1;
    busy_cnt = busy_o ? 1 : 0;
    while (!done_o && cyc < 40) begin
      @(negedge clk_i);
      cyc++;
      if (busy_o) busy_cnt++;
    end
    chk({tag, " latency"}, 32'(cyc), 32'd21);
    chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'd20);
    chk({tag, " bcd"}, 32'(bcd_o), 32'(exp_bcd));
    chk({tag, " ovf"}, 32'(ovf_o), 32'(exp_ovf));
    chk({tag, " busy_in_done"}, 32'(busy_o), 32'd0);
    @(negedge clk_i);
    chk({tag, " done_width"}, 32'(done_o), 32'd0);
    chk({tag, " done_count"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int cyc, d0, t1, t2;
    logic [19:0] rv;
    rst_i   = 1'b1;
    start_i = 1'b0;
    bin_i   = '0;
    repeat (3) @(negedge clk_i);
    chk("rst busy", 32'(busy_o), 32'd0);
    chk("rst done", 32'(done_o), 32'd0);
    chk("rst ovf", 32'(ovf_o), 32'd0);
    chk("rst bcd", 32'(bcd_o), 32'd0);
    rst_i = 1'b0;

    run_conv(20'd0,       24'h000000, 1'b0, "zero");
    run_conv(20'h1E240,   24'h123456, 1'b0, "v123456");
    run_conv(20'hF423F,   24'h999999, 1'b0, "v999999");
`ifdef BCD_SATURATE_EN
    run_conv(20'hF4240,   24'h999999, 1'b1, "v1000000");
    run_conv(20'hFFFFF,   24'h999999, 1'b1, "vmax");
`else
    run_conv(20'hF4240,   24'h000000, 1'b1, "v1000000");
    run_conv(20'hFFFFF,   24'h048575, 1'b1, "vmax");
`endif

    // abort mid-conversion; previous result had ovf=1 and nonzero bcd
    @(negedge clk_i);
    start_i = 1'b1;
    bin_i   = 20'd500000;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (9) @(negedge clk_i);
    rst_i = 1'b1;
    d0    = done_cnt;
    @(negedge clk_i);
    chk("abort busy", 32'(busy_o), 32'd0);
    chk("abort bcd", 32'(bcd_o), 32'd0);
    chk("abort ovf", 32'(ovf_o), 32'd0);
    rst_i = 1'b0;
    repeat (25) @(negedge clk_i);
    chk("abort no_done", 32'(done_cnt - d0), 32'd0);
    run_conv(20'd9, 24'h000009, 1'b0, "after_abort");

    // start and operand changes during SHIFT are ignored
    @(negedge clk_i);
    start_i = 1'b1;
    bin_i   = 20'd42;
    d0      = done_cnt;
    @(negedge clk_i);
    start_i = 1'b0;
    cyc     = 1;
    repeat (4) begin
      @(negedge clk_i);
      cyc++;
    end
    start_i = 1'b1;
    bin_i   = 20'd7;
    @(negedge clk_i);
    cyc++;
    bin_i = 20'h12345;
    repeat (2) begin
      @(negedge clk_i);
      cyc++;
    end
    start_i = 1'b0;
    while (!done_o && cyc < 40) begin
      @(negedge clk_i);
      cyc++;
    end
    chk("ignore latency", 32'(cyc), 32'd21);
    chk("ignore bcd", 32'(bcd_o), 32'h000042);
    repeat (30) @(negedge clk_i);
    chk("ignore done_count", 32'(done_cnt - d0), 32'd1);

    // start held high: one conversion every 22 cycles
    @(negedge clk_i);
    start_i = 1'b1;
    bin_i   = 20'd3;
    cyc     = 0;
    while (!done_o && cyc < 60) begin
      @(negedge clk_i);
      cyc++;
    end
    t1 = cyc_ctr;
    chk("b2b first_done", 32'(done_o), 32'd1);
    @(negedge clk_i);
    cyc = 0;
    while (!done_o && cyc < 60) begin
      @(negedge clk_i);
      cyc++;
    end
    t2 = cyc_ctr;
    start_i = 1'b0;
    chk("b2b period", 32'(t2 - t1), 32'd22);
    chk("b2b bcd", 32'(bcd_o), 32'h000003);
    repeat (30) @(negedge clk_i);

    for (int k = 0; k < 150; k++) begin
      rv = 20'($urandom_range(0, 20'hFFFFF));
      run_conv(rv, ref_bcd(32'(rv)), (rv > 20'd999999), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
